// File: rtl/dmem_pkg.sv
// Shared constants, trace-entry type and level-width helper for dmem_trace_unit.
package dmem_pkg;

  localparam int DEF_DATA_W      = 32;
  localparam int DEF_ADDR_W      = 5;
  localparam int DEF_CNT_W       = 10;
  localparam int DEF_TRACE_DEPTH = 16;

  // Entry layout at default widths; the top re-declares it with its own widths.
  typedef struct packed {
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] data;
    logic [DEF_CNT_W-1:0]  cycle;
  } trace_entry_t;

  function automatic int level_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Generic synchronous FIFO with occupancy level; head is zero while empty.
module trace_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       din_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       dout_o,
  output logic [$clog2(DEPTH):0] level_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [0:DEPTH-1];
  logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [LVL_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == LVL_W'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  // A pop on a full FIFO frees the slot the simultaneous push lands in.
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) wr_d = wr_q + PTR_W'(1);
    if (do_pop)  rd_d = rd_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + LVL_W'(1);
      2'b01:   cnt_d = cnt_q - LVL_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end

  assign dout_o  = empty_o ? '0 : mem_q[rd_q];
  assign level_o = cnt_q;

endmodule

// File: rtl/dmem_trace_unit.sv
// Data RAM, writeback mux and cycle counter with an optional timestamped store trace.
// Define DMEM_TRACE_EN to build the trace FIFO; otherwise the trace port is tied off.
module dmem_trace_unit
  import dmem_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int TRACE_DEPTH = DEF_TRACE_DEPTH
) (
  input  logic                              clk_150MHz,
  input  logic                              reset,
  input  logic [DATA_W-1:0]                 alu_result,
  input  logic [DATA_W-1:0]                 write_data,
  input  logic                              memwr,
  input  logic                              memtoreg,
  output logic [DATA_W-1:0]                 wb_data,
  output logic [CNT_W-1:0]                  cycle_cnt,
  output logic                              trace_valid,
  input  logic                              trace_ready,
  output logic [ADDR_W-1:0]                 trace_addr,
  output logic [DATA_W-1:0]                 trace_data,
  output logic [CNT_W-1:0]                  trace_cycle,
  output logic [level_w(TRACE_DEPTH)-1:0]   trace_level,
  output logic                              trace_overflow
);

  localparam int RAM_DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [0:RAM_DEPTH-1];
  logic [ADDR_W-1:0] ram_addr;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  assign ram_addr = alu_result[ADDR_W-1:0];

  // RAM holds data only, so it is deliberately left out of reset.
  always_ff @(posedge clk_150MHz) begin
    if (memwr) mem_q[ram_addr] <= write_data;
  end

  assign wb_data = memtoreg ? mem_q[ram_addr] : alu_result;

  assign cnt_d = cnt_q + CNT_W'(1);

  always_ff @(posedge clk_150MHz or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cycle_cnt = cnt_q;

`ifdef DMEM_TRACE_EN
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [CNT_W-1:0]  cycle;
  } entry_t;

  entry_t push_entry, head;
  logic   fifo_full, fifo_empty;
  logic   ovf_q, ovf_d;

  assign push_entry = '{addr: ram_addr, data: write_data, cycle: cnt_q};

  trace_fifo #(
    .DEPTH (TRACE_DEPTH),
    .WIDTH ($bits(entry_t))
  ) u_trace_fifo (
    .clk_i   (clk_150MHz),
    .rst_ni  (reset),
    .push_i  (memwr),
    .din_i   (push_entry),
    .pop_i   (trace_ready),
    .dout_o  (head),
    .level_o (trace_level),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Full implies a valid head, so a ready consumer always makes room.
  assign ovf_d = ovf_q | (memwr & fifo_full & ~trace_ready);

  always_ff @(posedge clk_150MHz or negedge reset) begin
    if (!reset) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end

  assign trace_valid    = !fifo_empty;
  assign trace_addr     = head.addr;
  assign trace_data     = head.data;
  assign trace_cycle    = head.cycle;
  assign trace_overflow = ovf_q;
`else
  logic unused_trace_ready;
  assign unused_trace_ready = trace_ready;

  assign trace_valid    = 1'b0;
  assign trace_addr     = '0;
  assign trace_data     = '0;
  assign trace_cycle    = '0;
  assign trace_level    = '0;
  assign trace_overflow = 1'b0;
`endif

endmodule
